// File: rtl/dac_control_if.sv
// EBI bus bundle for the DAC controller: address, write data, strobes and
// the registered read-back path.
interface dac_control_if;
  logic [18:0] addr;
  logic [15:0] data_in;
  logic        enable;
  logic        re;
  logic        wr;
  logic [15:0] data_out;

  modport master (output addr, data_in, enable, re, wr, input data_out);
  modport slave  (input addr, data_in, enable, re, wr, output data_out);
endinterface

// File: rtl/dac_control.sv
// EBI-mapped controller for an 8-channel serial DAC (16-bit SYNC-framed words, MSB first).
// Optional LDAC strobe output is built when DAC_LDAC_EN is defined.
module dac_control #(
  parameter int POSITION = 0,
  parameter int CLK_DIV  = 4
) (
  input  logic          clk,
  input  logic          reset,
  dac_control_if.slave  bus,
  output logic          dac_sclk,
  output logic          dac_nsync,
`ifdef DAC_LDAC_EN
  output logic          dac_nldac,
`endif
  output logic          dac_din
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_LDAC} state_t;

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic               r_half, w_half_nxt;
  logic [3:0]         r_bit, w_bit_nxt;
  logic [15:0]        r_shift, w_shift_nxt;
  logic               r_sclk, w_sclk_nxt;
  logic               r_nsync, w_nsync_nxt;
  logic               r_din, w_din_nxt;
  logic [2:0]         r_last, w_last_nxt;
  logic [7:0]         r_pending, w_pend_clr, w_pend_set;
  logic               r_ctrl_pending, w_ctrl_clr;
  logic [11:0]        r_value [8];
  logic [15:0]        r_ctrl_word;
  logic [15:0]        r_data_out;
  logic               w_ldac_bit;

  logic       w_sel, w_wr, w_wr_val, w_wr_ctrl, w_busy, w_div_end, w_found;
  logic [3:0] w_cmd;
  logic [2:0] w_ch, w_pick;
  logic       w_unused;

  assign w_sel     = bus.enable && (bus.addr[15:8] == 8'(POSITION));
  assign w_cmd     = bus.addr[3:0];
  assign w_ch      = bus.addr[6:4];
  assign w_wr      = w_sel && bus.wr;
  assign w_wr_val  = w_wr && (w_cmd == 4'h1);
  assign w_wr_ctrl = w_wr && (w_cmd == 4'h4);
  assign w_pend_set = w_wr_val ? (8'b1 << w_ch) : 8'b0;
  assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_busy    = (r_state != S_IDLE) || (|r_pending) || r_ctrl_pending;
  assign w_unused  = &{1'b0, bus.addr[18:16], bus.addr[7]};

`ifdef DAC_LDAC_EN
  logic r_ldac_req, r_nldac, w_nldac_nxt, w_ldac_clr, w_wr_ldac;
  assign w_wr_ldac  = w_wr && (w_cmd == 4'hC);
  assign w_ldac_bit = r_ldac_req;
  assign dac_nldac  = r_nldac;
`else
  assign w_ldac_bit = 1'b0;
`endif

  // Round-robin search starting just after the last channel served
  always_comb begin
    logic [2:0] idx;
    w_found = 1'b0;
    w_pick  = r_last;
    for (int i = 1; i <= 8; i++) begin
      idx = r_last + 3'(i);
      if (!w_found && r_pending[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = w_div_end ? '0 : r_div + DIV_W'(1);
    w_half_nxt  = r_half;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_sclk_nxt  = r_sclk;
    w_nsync_nxt = r_nsync;
    w_din_nxt   = r_din;
    w_last_nxt  = r_last;
    w_pend_clr  = 8'b0;
    w_ctrl_clr  = 1'b0;
`ifdef DAC_LDAC_EN
    w_nldac_nxt = r_nldac;
    w_ldac_clr  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_div_nxt   = '0;
        w_half_nxt  = 1'b0;
        w_bit_nxt   = 4'd0;
        w_sclk_nxt  = 1'b1;
        w_nsync_nxt = 1'b1;
        w_din_nxt   = 1'b0;
        if (r_ctrl_pending) begin
          w_shift_nxt = r_ctrl_word;
          w_din_nxt   = r_ctrl_word[15];
          w_ctrl_clr  = 1'b1;
          w_nsync_nxt = 1'b0;
          w_state_nxt = S_SHIFT;
        end else if (w_found) begin
          w_shift_nxt = {1'b0, w_pick, r_value[w_pick]};
          w_din_nxt   = 1'b0;
          w_pend_clr  = 8'b1 << w_pick;
          w_last_nxt  = w_pick;
          w_nsync_nxt = 1'b0;
          w_state_nxt = S_SHIFT;
        end
`ifdef DAC_LDAC_EN
        else if (r_ldac_req) begin
          w_nldac_nxt = 1'b0;
          w_state_nxt = S_LDAC;
        end
`endif
      end
      S_SHIFT: begin
        if (w_div_end) begin
          if (!r_half) begin
            w_half_nxt = 1'b1;
            w_sclk_nxt = 1'b0;
          end else begin
            w_half_nxt  = 1'b0;
            w_sclk_nxt  = 1'b1;
            w_shift_nxt = {r_shift[14:0], 1'b0};
            w_din_nxt   = r_shift[14];
            w_bit_nxt   = r_bit + 4'd1;
            if (r_bit == 4'd15) begin
              w_nsync_nxt = 1'b1;
              w_din_nxt   = 1'b0;
              w_state_nxt = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (w_div_end) begin
          w_half_nxt = ~r_half;
          if (r_half) w_state_nxt = S_IDLE;
        end
      end
      default: begin
`ifdef DAC_LDAC_EN
        if (w_div_end) begin
          w_half_nxt = ~r_half;
          if (r_half) begin
            w_nldac_nxt = 1'b1;
            w_ldac_clr  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_div          <= '0;
      r_half         <= 1'b0;
      r_bit          <= 4'd0;
      r_shift        <= 16'd0;
      r_sclk         <= 1'b1;
      r_nsync        <= 1'b1;
      r_din          <= 1'b0;
      r_last         <= 3'd7;
      r_pending      <= 8'd0;
      r_ctrl_pending <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_div          <= w_div_nxt;
      r_half         <= w_half_nxt;
      r_bit          <= w_bit_nxt;
      r_shift        <= w_shift_nxt;
      r_sclk         <= w_sclk_nxt;
      r_nsync        <= w_nsync_nxt;
      r_din          <= w_din_nxt;
      r_last         <= w_last_nxt;
      // A host write landing on the same clock as the FSM clear keeps the request
      r_pending      <= (r_pending & ~w_pend_clr) | w_pend_set;
      r_ctrl_pending <= (r_ctrl_pending & ~w_ctrl_clr) | w_wr_ctrl;
    end
  end

`ifdef DAC_LDAC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ldac_req <= 1'b0;
      r_nldac    <= 1'b1;
    end else begin
      r_ldac_req <= (r_ldac_req & ~w_ldac_clr) | w_wr_ldac;
      r_nldac    <= w_nldac_nxt;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_value[i] <= 12'd0;
      r_ctrl_word <= 16'd0;
    end else begin
      if (w_wr_val)  r_value[w_ch] <= bus.data_in[11:0];
      if (w_wr_ctrl) r_ctrl_word   <= {1'b1, bus.data_in[14:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= 16'd0;
    end else if (w_sel && bus.re) begin
      case (w_cmd)
        4'h9:    r_data_out <= 16'h0DAC;
        4'hA:    r_data_out <= {15'd0, w_busy};
        4'hB:    r_data_out <= {6'd0, w_ldac_bit, r_ctrl_pending, r_pending};
        default: r_data_out <= 16'd0;
      endcase
    end else begin
      r_data_out <= 16'd0;
    end
  end

  assign bus.data_out = r_data_out;
  assign dac_sclk     = r_sclk;
  assign dac_nsync    = r_nsync;
  assign dac_din      = r_din;

endmodule

// File: tb/tb_dac_control.sv
// Directed bench for dac_control: register vectors from a table, then serial-frame
// sequences decoded by a falling-sclk monitor on the DAC pins.
module tb_dac_control;

  logic clk, reset;
  logic dac_sclk, dac_nsync, dac_din;
`ifdef DAC_LDAC_EN
  logic dac_nldac;
`endif

  dac_control_if bus ();

  dac_control #(.POSITION(0), .CLK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dac_sclk  (dac_sclk),
    .dac_nsync (dac_nsync),
`ifdef DAC_LDAC_EN
    .dac_nldac (dac_nldac),
`endif
    .dac_din   (dac_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame monitor: samples pins on the negative edge
  logic [15:0] q_word [$];
  int          q_len  [$];
  int          q_falls[$];
  int          q_gap  [$];
  int          cyc = 0, low_cnt = 0, hi_cnt = 0, cur_falls = 0, rise_cyc = 0;
  logic [15:0] cur_word = 16'd0;
  logic        prev_n = 1'b1, prev_s = 1'b1, in_frame = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      in_frame  = 1'b0;
      prev_n    = 1'b1;
      prev_s    = 1'b1;
      hi_cnt    = 0;
      cur_falls = 0;
    end else begin
      if (prev_n && !dac_nsync) begin
        in_frame  = 1'b1;
        low_cnt   = 0;
        cur_word  = 16'd0;
        cur_falls = 0;
        q_gap.push_back(hi_cnt);
      end
      if (!dac_nsync) begin
        hi_cnt = 0;
        low_cnt++;
        if (prev_s && !dac_sclk) begin
          cur_word = {cur_word[14:0], dac_din};
          cur_falls++;
        end
      end else begin
        hi_cnt++;
      end
      if (!prev_n && dac_nsync && in_frame) begin
        q_word.push_back(cur_word);
        q_len.push_back(low_cnt);
        q_falls.push_back(cur_falls);
        in_frame = 1'b0;
        rise_cyc = cyc;
      end
      prev_n = dac_nsync;
      prev_s = dac_sclk;
    end
  end

`ifdef DAC_LDAC_EN
  int   ldac_fall_cyc = 0, ldac_low = 0, ldac_len = -1;
  logic prev_l = 1'b1;
  always @(negedge clk) begin
    if (prev_l && !dac_nldac) begin
      ldac_fall_cyc = cyc;
      ldac_low      = 0;
    end
    if (!dac_nldac) ldac_low++;
    if (!prev_l && dac_nldac) ldac_len = ldac_low;
    prev_l = dac_nldac;
  end
`endif

  task automatic clear_mon();
    q_word.delete();
    q_len.delete();
    q_falls.delete();
    q_gap.delete();
  endtask

  task automatic bus_write(input logic [18:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.data_in = d; bus.enable = 1'b1; bus.wr = 1'b1; bus.re = 1'b0;
    @(negedge clk);
    bus.enable = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [18:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.enable = 1'b1; bus.re = 1'b1; bus.wr = 1'b0;
    @(negedge clk);
    d = bus.data_out;
    bus.enable = 1'b0; bus.re = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (q_word.size() < n && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("frames_seen", q_word.size(), n);
  endtask

  task automatic wait_nsync_low();
    int k = 0;
    while (dac_nsync !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("nsync_fell", dac_nsync, 1'b0);
  endtask

  task automatic check_frame(input int idx, input logic [15:0] exp);
    if (idx < q_word.size()) begin
      check($sformatf("frame%0d_word", idx), q_word[idx], exp);
      check($sformatf("frame%0d_len", idx), q_len[idx], 128);
      check($sformatf("frame%0d_falls", idx), q_falls[idx], 16);
    end else begin
      check($sformatf("frame%0d_present", idx), q_word.size(), idx + 1);
    end
  endtask

  typedef struct {
    string       name;
    logic        en;
    logic        re;
    logic        wr;
    logic [18:0] addr;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [11];
  logic [15:0] rd;

  initial begin
    vecs[0]  = '{"rd_id",       1'b1, 1'b1, 1'b0, 19'h00009, 16'h0000, 16'h0DAC};
    vecs[1]  = '{"rd_busy",     1'b1, 1'b1, 1'b0, 19'h0000A, 16'h0000, 16'h0000};
    vecs[2]  = '{"rd_pend",     1'b1, 1'b1, 1'b0, 19'h0000B, 16'h0000, 16'h0000};
    vecs[3]  = '{"rd_cmd0",     1'b1, 1'b1, 1'b0, 19'h00000, 16'h0000, 16'h0000};
    vecs[4]  = '{"rd_cmd5",     1'b1, 1'b1, 1'b0, 19'h000F5, 16'h0000, 16'h0000};
    vecs[5]  = '{"rd_unsel",    1'b1, 1'b1, 1'b0, 19'h00109, 16'h0000, 16'h0000};
    vecs[6]  = '{"rd_noen",     1'b0, 1'b1, 1'b0, 19'h00009, 16'h0000, 16'h0000};
    vecs[7]  = '{"wr_unsel",    1'b1, 1'b0, 1'b1, 19'h00131, 16'h0123, 16'h0000};
    vecs[8]  = '{"wr_cmd2",     1'b1, 1'b0, 1'b1, 19'h00032, 16'h0456, 16'h0000};
    vecs[9]  = '{"rd_pend_ign", 1'b1, 1'b1, 1'b0, 19'h0000B, 16'h0000, 16'h0000};
    vecs[10] = '{"rd_id_hiadr", 1'b1, 1'b1, 1'b0, 19'h70009, 16'h0000, 16'h0DAC};

    reset = 1'b1;
    bus.addr = '0; bus.data_in = '0; bus.enable = 1'b0; bus.re = 1'b0; bus.wr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_nsync", dac_nsync, 1'b1);
    check("rst_sclk", dac_sclk, 1'b1);
    check("rst_din", dac_din, 1'b0);
    check("rst_data_out", bus.data_out, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.enable = vecs[i].en; bus.re = vecs[i].re; bus.wr = vecs[i].wr;
      bus.addr = vecs[i].addr; bus.data_in = vecs[i].din;
      @(negedge clk);
      check(vecs[i].name, bus.data_out, vecs[i].exp);
      bus.enable = 1'b0; bus.re = 1'b0; bus.wr = 1'b0;
    end
    check("no_frame_after_table", q_word.size(), 0);

    // Single frame on ch3, upper data bits dropped
    clear_mon();
    bus_write(19'h00031, 16'hFABC);
    bus_read(19'h0000A, rd);
    check("busy_in_frame", rd, 16'h0001);
    wait_frames(1);
    check_frame(0, 16'h3ABC);
    bus_read(19'h0000A, rd);
    check("busy_in_gap", rd, 16'h0001);
    repeat (8) @(negedge clk);
    bus_read(19'h0000A, rd);
    check("busy_after", rd, 16'h0000);

    // CTRL overtakes a pending channel; second CTRL overwrites the first
    clear_mon();
    bus_write(19'h00071, 16'h0777);
    wait_nsync_low();
    bus_write(19'h00004, 16'h0999);
    bus_write(19'h000D1, 16'hF555);
    bus_write(19'h00004, 16'h0123);
    bus_read(19'h0000B, rd);
    check("pend_ctrl_ch5", rd, 16'h0120);
    wait_frames(3);
    check_frame(0, 16'h7777);
    check_frame(1, 16'h8123);
    check_frame(2, 16'h5555);
    if (q_gap.size() >= 3) begin
      check("gap_1_2", q_gap[1], 9);
      check("gap_2_3", q_gap[2], 9);
    end else begin
      check("gap_count", q_gap.size(), 3);
    end

    // Round robin from last=1
    repeat (12) @(negedge clk);
    clear_mon();
    bus_write(19'h00011, 16'h00AA);
    wait_nsync_low();
    bus_write(19'h00001, 16'h00C0);
    bus_write(19'h00021, 16'h02C2);
    bus_write(19'h00061, 16'h06C6);
    wait_frames(4);
    check_frame(0, 16'h10AA);
    check_frame(1, 16'h22C2);
    check_frame(2, 16'h66C6);
    check_frame(3, 16'h00C0);

    // Rewrite of the channel being shifted
    repeat (12) @(negedge clk);
    clear_mon();
    bus_write(19'h00011, 16'h0111);
    wait_nsync_low();
    bus_write(19'h00011, 16'h0222);
    wait_frames(1);
    bus_read(19'h0000B, rd);
    check("pend_between", rd, 16'h0002);
    wait_frames(2);
    check_frame(0, 16'h1111);
    check_frame(1, 16'h1222);

    // Asynchronous reset mid-frame
    repeat (12) @(negedge clk);
    clear_mon();
    bus_write(19'h00041, 16'h0444);
    wait_nsync_low();
    bus_write(19'h00021, 16'h02AA);
    begin
      int k = 0;
      while (cur_falls < 7 && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("reached_bit7", (cur_falls >= 7), 1'b1);
    end
    check("pre_rst_nsync", dac_nsync, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("arst_nsync", dac_nsync, 1'b1);
    check("arst_sclk", dac_sclk, 1'b1);
    check("arst_din", dac_din, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_mon();
    bus_read(19'h0000B, rd);
    check("arst_pend", rd, 16'h0000);
    bus_read(19'h0000A, rd);
    check("arst_busy", rd, 16'h0000);
    repeat (20) @(negedge clk);
    check("arst_no_frame", q_word.size(), 0);

`ifdef DAC_LDAC_EN
    clear_mon();
    bus_write(19'h00041, 16'h0444);
    wait_nsync_low();
    bus_write(19'h0000C, 16'h0000);
    bus_read(19'h0000B, rd);
    check("pend_ldac", rd, 16'h0200);
    wait_frames(1);
    check_frame(0, 16'h4444);
    begin
      int k = 0;
      while (ldac_len < 0 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    check("ldac_delay", ldac_fall_cyc - rise_cyc, 9);
    check("ldac_len", ldac_len, 8);
    bus_read(19'h0000B, rd);
    check("ldac_cleared", rd, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
